// File: rtl/fp64_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp64_mul_arbiter_if
//   Request/response bundle between the requesting engines and the FP64
//   multiplier arbiter.
//
//   req_valid  NUM_REQ      per-requester operation request
//   req_ready  NUM_REQ      per-requester grant (one-hot or zero)
//   req_a      NUM_REQ*64   operand A, requester i in bits [64*i+63:64*i]
//   req_b      NUM_REQ*64   operand B, same packing as req_a
//   rsp_valid  1            result valid (no backpressure)
//   rsp_id     ID_W         owner of rsp_data
//   rsp_data   64           FP64 product
//
//   master: requester side, slave: arbiter side.
// -----------------------------------------------------------------------------
interface fp64_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/fp64_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp64_mul_arbiter
//   Shares one fixed-latency pipelined FP64 multiplier among NUM_REQ
//   requesters. A round-robin arbiter issues at most one operation per cycle,
//   a tag pipeline tracks the owner of every in-flight operation and each
//   result is returned with the ID of the requester that issued it.
//
//   Ports
//     clk           clock, rising edge
//     rst_n         synchronous reset, active low
//     bus           fp64_mul_arbiter_if.slave (req_* in, req_ready/rsp_* out)
//     mul_in_valid  issue strobe to the multiplier
//     mul_a, mul_b  operands to the multiplier
//     mul_result    multiplier result
//     mul_valid     multiplier result valid
//     inflight      operations issued but not yet returned
//     err           sticky tag/valid mismatch flag
//
//   Optional feature: define FP64_ARB_ERRCHK_EN to build the tag/valid
//   checker. Without it err is tied to 0.
//
//   Latency handshake -> rsp_valid is MUL_LAT+2 cycles: one issue register,
//   MUL_LAT multiplier stages, one response register.
// -----------------------------------------------------------------------------
module fp64_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fp64_mul_arbiter_if.slave bus,
  output logic              mul_in_valid,
  output logic [63:0]       mul_a,
  output logic [63:0]       mul_b,
  input  logic [63:0]       mul_result,
  input  logic              mul_valid,
  output logic [ID_W+1:0]   inflight,
  output logic              err
);

  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    ptr_next;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [ID_W:0]      scan_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               transfer;

  logic [63:0]        op_a [NUM_REQ];
  logic [63:0]        op_b [NUM_REQ];

  logic               issue_valid_reg;
  logic [ID_W-1:0]    issue_id_reg;
  logic [63:0]        mul_a_reg;
  logic [63:0]        mul_b_reg;

  logic [MUL_LAT-1:0] tag_valid_reg;
  logic [ID_W-1:0]    tag_id_reg [MUL_LAT];
  logic               tail_valid;
  logic [ID_W-1:0]    tail_id;

  logic               rsp_fire;
  logic               ret_tagged;
  logic               rsp_valid_reg;
  logic [ID_W-1:0]    rsp_id_reg;
  logic [63:0]        rsp_data_reg;
  logic [ID_W+1:0]    inflight_reg;
  logic [ID_W+1:0]    inflight_next;

  // Unpack the flat operand buses so the issue mux is a plain array index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi] = bus.req_a[64*gi +: 64];
    assign op_b[gi] = bus.req_b[64*gi +: 64];
  end

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_any && bus.req_valid[scan_idx[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx[ID_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant_onehot[gi] = grant_any && (grant_id == ID_W'(gi));
  end

  // Grants are suppressed while reset is held so nothing transfers.
  assign bus.req_ready = rst_n ? grant_onehot : '0;
  assign transfer      = rst_n & grant_any;
  assign ptr_next      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  assign tail_valid = tag_valid_reg[MUL_LAT-1];
  assign tail_id    = tag_id_reg[MUL_LAT-1];

  // Only results that line up with a live tag count as returned operations;
  // this is what discards multiplier output belonging to pre-reset issues.
  assign ret_tagged = mul_valid & tail_valid;

`ifdef FP64_ARB_ERRCHK_EN
  logic err_reg;

  // With the checker built, a mismatching result is still forwarded so the
  // fault is visible downstream alongside err.
  assign rsp_fire = mul_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (mul_valid != tail_valid) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign rsp_fire = ret_tagged;
  assign err      = 1'b0;
`endif

  always_comb begin
    inflight_next = inflight_reg;
    if (transfer && !ret_tagged) begin
      inflight_next = inflight_reg + 1'b1;
    end else if (!transfer && ret_tagged) begin
      inflight_next = inflight_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg         <= '0;
      issue_valid_reg <= 1'b0;
      issue_id_reg    <= '0;
      mul_a_reg       <= '0;
      mul_b_reg       <= '0;
      tag_valid_reg   <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_id_reg[s] <= '0;
      end
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_data_reg    <= '0;
      inflight_reg    <= '0;
    end else begin
      issue_valid_reg <= transfer;
      if (transfer) begin
        ptr_reg      <= ptr_next;
        issue_id_reg <= grant_id;
        mul_a_reg    <= op_a[grant_id];
        mul_b_reg    <= op_b[grant_id];
      end

      // Stage 0 is loaded from the issue register so the tail lines up with
      // mul_valid exactly MUL_LAT cycles after mul_in_valid.
      tag_valid_reg[0] <= issue_valid_reg;
      tag_id_reg[0]    <= issue_id_reg;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end

      rsp_valid_reg <= rsp_fire;
      if (rsp_fire) begin
        rsp_data_reg <= mul_result;
        rsp_id_reg   <= tail_id;
      end

      inflight_reg <= inflight_next;
    end
  end

  assign mul_in_valid  = issue_valid_reg;
  assign mul_a         = mul_a_reg;
  assign mul_b         = mul_b_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign inflight      = inflight_reg;

endmodule
